arrow_lane_scheduler: RTL and testbench

//  Tracks up to SLOTS scrolling arrow notes across 4 lanes and moves each one up the screen once per frame.

---
 rtl/arrow_lane_scheduler_if.sv | 33 +++
 rtl/arrow_lane_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_arrow_lane_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/arrow_lane_scheduler_if.sv
// Bus between the chart/input logic, the arrow lane scheduler and the color mapper.
// master drives spawn/hit requests and the current pixel; slave is the scheduler.
interface arrow_lane_scheduler_if;
   logic       frame_tick;
   logic [3:0] speed;
   logic       spawn_valid;
   logic [1:0] spawn_lane;
   logic       spawn_ready;
   logic       hit_valid;
   logic [1:0] hit_lane;
   logic       hit_ready;
   logic       hit_result_valid;
   logic [1:0] hit_result;
   logic       miss_pulse;
   logic [4:0] active_count;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       arrow_on;
   logic [1:0] arrow_lane;
   logic [9:0] SpriteX;
   logic [9:0] SpriteY;

   modport master (
      output frame_tick, speed, spawn_valid, spawn_lane, hit_valid, hit_lane, DrawX, DrawY,
      input  spawn_ready, hit_ready, hit_result_valid, hit_result, miss_pulse, active_count,
             arrow_on, arrow_lane, SpriteX, SpriteY
   );
   modport slave (
      input  frame_tick, speed, spawn_valid, spawn_lane, hit_valid, hit_lane, DrawX, DrawY,
      output spawn_ready, hit_ready, hit_result_valid, hit_result, miss_pulse, active_count,
             arrow_on, arrow_lane, SpriteX, SpriteY
   );
endinterface

// File: rtl/arrow_lane_scheduler.sv
// Arrow slot tracker: spawns notes, scrolls them once per frame, judges hits and picks the sprite per pixel.
// Optional ARROW_SCHED_AUTOPLAY_EN: arrows crossing the receptor line during UPDATE score PERFECT automatically.
module arrow_lane_scheduler #(
   parameter int SLOTS      = 8,
   parameter int ARROW_SIZE = 32,
   parameter int SCREEN_H   = 480,
   parameter int TARGET_Y   = 48,
   parameter int LANE_X0    = 192,
   parameter int LANE_PITCH = 64,
   parameter int PERFECT_W  = 4,
   parameter int GOOD_W     = 16
) (
   input logic Clk,
   input logic Reset,
   arrow_lane_scheduler_if.slave bus
);
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
   localparam logic [1:0] RES_MISS = 2'd0, RES_GOOD = 2'd1, RES_PERFECT = 2'd2;

   typedef enum logic [1:0] {IDLE, UPDATE, HIT_SCAN, HIT_RESOLVE} state_t;

   state_t           state_q, state_d;
   logic [SLOTS-1:0] valid_q, valid_d;
   logic [1:0]       lane_q [SLOTS];
   logic [1:0]       lane_d [SLOTS];
   logic [9:0]       y_q [SLOTS];
   logic [9:0]       y_d [SLOTS];
   logic [IDX_W-1:0] idx_q, idx_d, best_q, best_d, free_idx;
   logic             pend_q, pend_d, found_q, found_d, free_found;
   logic [3:0]       spd_q, spd_d;
   logic [1:0]       hlane_q, hlane_d;
   logic [9:0]       bestd_q, bestd_d, cur_y, cur_d;
   logic [4:0]       count_q;
   logic             miss, res_valid, spawn_rdy, hit_rdy;
   logic [1:0]       result;
   logic             pix_on, arrow_on_q;
   logic [1:0]       pix_lane, arrow_lane_q;
   logic [9:0]       pix_sx, pix_sy, sprite_x_q, sprite_y_q, lane_x;

   function automatic logic [9:0] target_dist(input logic [9:0] y);
      return (y >= 10'(TARGET_Y)) ? y - 10'(TARGET_Y) : 10'(TARGET_Y) - y;
   endfunction

   function automatic logic [4:0] popcount(input logic [SLOTS-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < SLOTS; i++) c = c + 5'(v[i]);
      return c;
   endfunction

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      lane_d    = lane_q;
      y_d       = y_q;
      idx_d     = idx_q;
      pend_d    = pend_q | bus.frame_tick;
      spd_d     = spd_q;
      hlane_d   = hlane_q;
      found_d   = found_q;
      best_d    = best_q;
      bestd_d   = bestd_q;
      miss      = 1'b0;
      res_valid = 1'b0;
      result    = RES_MISS;
      spawn_rdy = 1'b0;
      hit_rdy   = 1'b0;
      cur_y     = y_q[idx_q];
      cur_d     = target_dist(cur_y);
      case (state_q)
         IDLE: begin
`ifdef ARROW_SCHED_AUTOPLAY_EN
            hit_rdy = 1'b0;
`else
            hit_rdy = !pend_q;
`endif
            spawn_rdy = !pend_q && !bus.hit_valid && free_found;
            if (pend_q) begin
               state_d = UPDATE;
               pend_d  = bus.frame_tick;
               idx_d   = '0;
               spd_d   = bus.speed;
            end else if (bus.hit_valid && hit_rdy) begin
               state_d = HIT_SCAN;
               hlane_d = bus.hit_lane;
               idx_d   = '0;
               found_d = 1'b0;
            end else if (bus.spawn_valid && spawn_rdy) begin
               valid_d[free_idx] = 1'b1;
               lane_d[free_idx]  = bus.spawn_lane;
               y_d[free_idx]     = 10'(SCREEN_H);
            end
         end
         UPDATE: begin
            if (valid_q[idx_q]) begin
               if (cur_y < 10'(spd_q)) begin
                  valid_d[idx_q] = 1'b0;
                  miss           = 1'b1;
               end else begin
                  y_d[idx_q] = cur_y - 10'(spd_q);
`ifdef ARROW_SCHED_AUTOPLAY_EN
                  if (cur_y > 10'(TARGET_Y) && (cur_y - 10'(spd_q)) <= 10'(TARGET_Y)) begin
                     valid_d[idx_q] = 1'b0;
                     res_valid      = 1'b1;
                     result         = RES_PERFECT;
                  end
`endif
               end
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = IDLE;
         end
         HIT_SCAN: begin
            // strict '<' while scanning upward keeps the lower index on ties
            if (valid_q[idx_q] && lane_q[idx_q] == hlane_q && (!found_q || cur_d < bestd_q)) begin
               found_d = 1'b1;
               best_d  = idx_q;
               bestd_d = cur_d;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = HIT_RESOLVE;
         end
         HIT_RESOLVE: begin
            res_valid = 1'b1;
            state_d   = IDLE;
            if (found_q && bestd_q <= 10'(PERFECT_W)) begin
               result         = RES_PERFECT;
               valid_d[best_q] = 1'b0;
            end else if (found_q && bestd_q <= 10'(GOOD_W)) begin
               result         = RES_GOOD;
               valid_d[best_q] = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Descending scan so the lowest-index covering slot is the one that sticks.
   always_comb begin
      pix_on   = 1'b0;
      pix_lane = '0;
      pix_sx   = '0;
      pix_sy   = '0;
      lane_x   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         lane_x = 10'(LANE_X0) + 10'(LANE_PITCH) * {8'd0, lane_q[i]};
         if (valid_q[i] && bus.DrawX >= lane_x && {1'b0, bus.DrawX} < {1'b0, lane_x} + 11'(ARROW_SIZE)
             && bus.DrawY >= y_q[i] && {1'b0, bus.DrawY} < {1'b0, y_q[i]} + 11'(ARROW_SIZE)) begin
            pix_on   = 1'b1;
            pix_lane = lane_q[i];
            pix_sx   = 10'(ARROW_SIZE) - (bus.DrawX - lane_x);
            pix_sy   = 10'(ARROW_SIZE) - (bus.DrawY - y_q[i]);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         spd_q        <= '0;
         hlane_q      <= '0;
         found_q      <= 1'b0;
         best_q       <= '0;
         bestd_q      <= '0;
         count_q      <= '0;
         arrow_on_q   <= 1'b0;
         arrow_lane_q <= '0;
         sprite_x_q   <= '0;
         sprite_y_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         spd_q        <= spd_d;
         hlane_q      <= hlane_d;
         found_q      <= found_d;
         best_q       <= best_d;
         bestd_q      <= bestd_d;
         count_q      <= popcount(valid_q);
         arrow_on_q   <= pix_on;
         arrow_lane_q <= pix_lane;
         sprite_x_q   <= pix_sx;
         sprite_y_q   <= pix_sy;
      end
   end

   // Lane/position payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge Clk) begin
      lane_q <= lane_d;
      y_q    <= y_d;
   end

   assign bus.spawn_ready      = spawn_rdy & ~Reset;
   assign bus.hit_ready        = hit_rdy & ~Reset;
   assign bus.hit_result_valid = res_valid & ~Reset;
   assign bus.hit_result       = result & {2{res_valid & ~Reset}};
   assign bus.miss_pulse       = miss & ~Reset;
   assign bus.active_count     = count_q;
   assign bus.arrow_on         = arrow_on_q;
   assign bus.arrow_lane       = arrow_lane_q;
   assign bus.SpriteX          = sprite_x_q;
   assign bus.SpriteY          = sprite_y_q;
endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// Directed bench for arrow_lane_scheduler; hit judgements go through an expected-result queue.
module tb_arrow_lane_scheduler;
   localparam int SLOTS = 8;
   localparam int LANE_X0 = 192;
   localparam int SCREEN_H = 480;
   localparam logic [1:0] R_MISS = 2'd0, R_GOOD = 2'd1, R_PERFECT = 2'd2;

   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   failures = 0;
   int   miss_seen = 0;
   logic [1:0] exp_q [$];

   arrow_lane_scheduler_if bus ();

   arrow_lane_scheduler #(.SLOTS(SLOTS)) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) if (bus.miss_pulse === 1'b1) miss_seen++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.frame_tick  = 1'b0;
      bus.spawn_valid = 1'b0;
      bus.spawn_lane  = 2'd0;
      bus.hit_valid   = 1'b0;
      bus.hit_lane    = 2'd0;
      bus.DrawX       = 10'd0;
      bus.DrawY       = 10'd0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         bus.frame_tick = 1'b1;
         @(negedge Clk);
         bus.frame_tick = 1'b0;
         cycles(SLOTS + 5);
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      Reset = 1'b1;
      cycles(2);
      Reset = 1'b0;
      cycles(1);
   endtask

   task automatic spawn(input logic [1:0] lane);
      int n;
      n = 0;
      bus.spawn_valid = 1'b1;
      bus.spawn_lane  = lane;
      #1;
      while (bus.spawn_ready !== 1'b1 && n < 50) begin
         @(negedge Clk);
         #1;
         n++;
      end
      check("spawn_accept", int'(bus.spawn_ready), 1);
      @(negedge Clk);
      bus.spawn_valid = 1'b0;
   endtask

   // Ticks (0..2) are pulsed while the scan is in progress.
   task automatic do_hit(input logic [1:0] lane, input logic [1:0] exp, input int ticks);
      int n;
      int lat;
      logic [1:0] want;
      n = 0;
      bus.hit_valid = 1'b1;
      bus.hit_lane  = lane;
      #1;
      while (bus.hit_ready !== 1'b1 && n < 50) begin
         @(negedge Clk);
         #1;
         n++;
      end
      check("hit_accept", int'(bus.hit_ready), 1);
      exp_q.push_back(exp);
      @(negedge Clk);
      bus.hit_valid = 1'b0;
      lat = 1;
      while (bus.hit_result_valid !== 1'b1 && lat < 40) begin
         bus.frame_tick = (lat == 2 && ticks >= 1) || (lat == 4 && ticks >= 2);
         @(negedge Clk);
         lat++;
      end
      bus.frame_tick = 1'b0;
      check("hit_latency", lat, SLOTS + 1);
      want = exp_q.pop_front();
      check("hit_result", int'(bus.hit_result), int'(want));
      @(negedge Clk);
      check("hit_pulse_len", int'(bus.hit_result_valid), 0);
   endtask

   task automatic pix(input string tag, input int x, input int y,
                      input int on, input int ln, input int sx, input int sy);
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      @(negedge Clk);
      check({tag, "_on"}, int'(bus.arrow_on), on);
      check({tag, "_lane"}, int'(bus.arrow_lane), ln);
      check({tag, "_sx"}, int'(bus.SpriteX), sx);
      check({tag, "_sy"}, int'(bus.SpriteY), sy);
   endtask

   initial begin
      int m0;
      idle_inputs();
      bus.speed = 4'd4;
      Reset = 1'b1;
      cycles(3);
      check("rst_spawn_ready", int'(bus.spawn_ready), 0);
      check("rst_hit_ready", int'(bus.hit_ready), 0);
      check("rst_result_valid", int'(bus.hit_result_valid), 0);
      check("rst_miss", int'(bus.miss_pulse), 0);
      check("rst_active", int'(bus.active_count), 0);
      check("rst_arrow_on", int'(bus.arrow_on), 0);
      check("rst_sprite_x", int'(bus.SpriteX), 0);
      check("rst_sprite_y", int'(bus.SpriteY), 0);
      Reset = 1'b0;
      @(negedge Clk);
      check("post_rst_spawn_ready", int'(bus.spawn_ready), 1);
      check("post_rst_hit_ready", int'(bus.hit_ready), 1);

      // PERFECT: 480 - 4*108 = 48, exactly on the receptor line
      spawn(2'd2);
      frames(108);
      check("perfect_active", int'(bus.active_count), 1);
      pix("perfect_pos", LANE_X0 + 2 * 64, 48, 1, 2, 32, 32);
      do_hit(2'd2, R_PERFECT, 0);
      cycles(2);
      check("perfect_cleared", int'(bus.active_count), 0);

      // GOOD: y = 480 - 4*104 = 64, distance 16
      spawn(2'd0);
      frames(104);
      do_hit(2'd0, R_GOOD, 0);
      cycles(2);
      check("good_cleared", int'(bus.active_count), 0);

      // MISS: y = 80, distance 32, arrow stays
      spawn(2'd0);
      frames(100);
      do_hit(2'd0, R_MISS, 0);
      cycles(2);
      check("miss_kept", int'(bus.active_count), 1);
      pix("miss_corner", LANE_X0 + 31, 80 + 31, 1, 0, 1, 1);
      pix("miss_xedge", LANE_X0 + 32, 80 + 31, 0, 0, 0, 0);
      do_hit(2'd3, R_MISS, 0);

      // Fill all slots, then scroll them off at speed 15: 480/15 = 32 frames reach y=0, the 33rd retires
      do_reset();
      bus.speed = 4'd15;
      for (int i = 0; i < SLOTS; i++) spawn(2'(i));
      cycles(2);
      check("full_spawn_ready", int'(bus.spawn_ready), 0);
      check("full_active", int'(bus.active_count), SLOTS);
      m0 = miss_seen;
      frames(32);
      check("scroll32_misses", miss_seen - m0, 0);
      check("scroll32_active", int'(bus.active_count), SLOTS);
      frames(1);
      check("scroll33_misses", miss_seen - m0, SLOTS);
      check("scroll33_active", int'(bus.active_count), 0);

      // Two ticks during the scan collapse into one UPDATE after the result
      do_reset();
      bus.speed = 4'd4;
      spawn(2'd1);
      bus.DrawX = 10'(LANE_X0 + 64 + 5);
      bus.DrawY = 10'(SCREEN_H - 4);
      cycles(2);
      check("tick_pre_on", int'(bus.arrow_on), 0);
      do_hit(2'd1, R_MISS, 2);
      cycles(SLOTS + 6);
      check("tick_on", int'(bus.arrow_on), 1);
      check("tick_sy", int'(bus.SpriteY), 32);
      cycles(SLOTS + 6);
      check("tick_single_update", int'(bus.SpriteY), 32);

      // Overlap: slots 1 and 3 in lane 1 at y=100 and y=110
      do_reset();
      bus.speed = 4'd10;
      spawn(2'd0);
      spawn(2'd1);
      spawn(2'd2);
      frames(1);
      spawn(2'd1);
      frames(37);
      pix("ovl", LANE_X0 + 64 + 5, 112, 1, 1, 27, 20);
      pix("ovl_above", LANE_X0 + 64 + 5, 99, 0, 0, 0, 0);
      pix("ovl_slot3", LANE_X0 + 64 + 5, 140, 1, 1, 27, 2);
      pix("ovl_lastcol", LANE_X0 + 64 + 31, 100, 1, 1, 1, 32);

      // Reset in the middle of an UPDATE discards everything
      m0 = miss_seen;
      bus.frame_tick = 1'b1;
      @(negedge Clk);
      bus.frame_tick = 1'b0;
      cycles(3);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      cycles(SLOTS + 4);
      check("midrst_active", int'(bus.active_count), 0);
      check("midrst_arrow_on", int'(bus.arrow_on), 0);
      check("midrst_misses", miss_seen - m0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
